// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  function automatic logic store_func3_legal(input logic [2:0] func3);
    return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
  endfunction

  function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if ((func3 == F3_H || func3 == F3_HU) && addr_lo[0]) bad = 1'b1;
    if (func3 == F3_W && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Combinational load extraction: selects byte/half/word lane and sign/zero extends.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data     = '0;
    illegal  = 1'b0;
    case (func3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = word;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder with fixed response latency.
// Optional alignment faults enabled by defining MISALIGN_CHECK_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] word_q;
  logic [2:0]  func3_q;
  logic [1:0]  addr_lo_q;
  logic        write_q;
  logic        err_q;

  logic          accept;
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          acc_err;
  logic          align_err;
  logic [31:0]   ext_data;
  logic          ext_illegal;

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = word_idx < DEPTH_L;

`ifdef MISALIGN_CHECK_EN
  assign align_err = misaligned(req_func3, req_addr[1:0]);
`else
  assign align_err = 1'b0;
`endif

  // Illegal load func3 is flagged later by load_extend on the captured value.
  assign acc_err = !in_range || align_err || (req_write && !store_func3_legal(req_func3));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q    <= '0;
      func3_q   <= '0;
      addr_lo_q <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      word_q    <= (!req_write && in_range) ? mem[mem_idx] : '0;
      func3_q   <= req_func3;
      addr_lo_q <= req_addr[1:0];
      write_q   <= req_write;
      err_q     <= acc_err;
    end
  end

  // Storage is intentionally not reset; stores commit on the accept edge.
  always_ff @(posedge clock) begin
    if (accept && !reset && req_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  load_extend u_load_extend (
    .word    (word_q),
    .func3   (func3_q),
    .addr_lo (addr_lo_q),
    .data    (ext_data),
    .illegal (ext_illegal)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && (err_q || (!write_q && ext_illegal));
  assign resp_rdata = (resp_valid && !write_q && !resp_err) ? ext_data : '0;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs byte-strobed writes and sized, sign- or zero-extended reads on an internal word array.
- Returns a response after a fixed, parameterised latency. Replaces the zero-latency memory inside the datapath when the processor moves to a handshaked memory bus.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the storage array.
- LATENCY, 2: cycles from request accept to first resp_valid; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned by the initiator.
- req_wstrb  in  4  byte write enables; ignored for loads.
- req_func3  in  3  RV32I access size/sign; same encoding as the load/store func3 field.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access fault on this transaction.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, latency counter=0. Array contents are not reset.
- Reset during WAIT or RESP drops the pending response. A store already committed at accept stays committed.
- Only one transaction is outstanding. req_ready=1 only in IDLE.
- Accept occurs when req_valid && req_ready at a rising edge. On that edge:
  - the word index addr[31:2] is computed;
  - the error flag is determined;
  - a store updates the lanes selected by req_wstrb, unless there is an error;
  - a load captures the full word and latches func3 and addr[1:0].
- FSM:
  - IDLE -> WAIT on accept, with the counter loaded to LATENCY-1. If LATENCY=1, IDLE -> RESP directly.
  - WAIT decrements the counter each cycle and moves to RESP when the counter is 1.
  - RESP drives resp_valid=1 and holds rdata/err stable until resp_ready. The edge where resp_valid && resp_ready is true moves to IDLE.
  - Next accept is possible no earlier than the cycle after the handshake.
- Timing: accept at cycle t gives resp_valid at cycle t+LATENCY, assuming resp_ready is already high.
- Load extraction, applied to the captured word using the latched addr[1:0]:
  - 000 LB: byte at addr[1:0], sign-extended.
  - 100 LBU: byte at addr[1:0], zero-extended.
  - 001 LH: half at addr[1], sign-extended.
  - 101 LHU: half at addr[1], zero-extended.
  - 010 LW: full word.
  - Other codes: rdata=0, err=1.
- Store func3 codes: 000 SB, 001 SH, 010 SW. Any other code gives err=1 and the write is suppressed.
- A store with req_wstrb=0 changes nothing; it still produces a response with err=0.
- Out of range (word index >= DEPTH_WORDS): err=1, store suppressed, rdata=0.
- Every store returns a response with rdata=0.
- Inputs are not sampled outside the accept edge. Changes to req_* while in WAIT or RESP have no effect.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Half accesses (func3 001/101) with addr[0]=1 give err=1.
  - Word accesses (010) with addr[1:0]!=0 give err=1.
  - On a misalignment error the store is suppressed and rdata=0.
- Undefined:
  - No alignment check; low address bits only select lanes as above.
  - err is raised only for out-of-range addresses or illegal func3.

Decomposition:
- Shared package mem_pkg:
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  - max-latency constant and counter-width localparam.
- One sub-module, load_extend: purely combinational. Inputs: word, func3, addr[1:0]. Outputs: extended data and illegal-func3 flag. Instantiated once on the response path.

Test Plan:
- SW at 0x10 with wdata 0xDEADBEEF, wstrb 1111, then LW at 0x10 (LATENCY=2) -> store response at t+2 with err=0, rdata=0; load response rdata=0xDEADBEEF at t+2.
- With word 0x10 = 0xDEADBEEF: LB at 0x11 -> 0xFFFFFFBE; LBU at 0x11 -> 0x000000BE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x12 -> 0x0000DEAD.
- SB at 0x13 with wdata 0x55000000, wstrb 1000, then LW at 0x10 -> 0x55ADBEEF.
- Load issued, resp_ready held low 5 cycles -> resp_valid and rdata stable all 5 cycles, req_ready=0 throughout; IDLE one cycle after the handshake.
- SW to byte address 4*DEPTH_WORDS -> err=1, no array change. With MISALIGN_CHECK_EN, LW at 0x12 -> err=1, rdata=0. Without it, the same LW -> err=0.
- reset asserted during WAIT of a load -> next cycle resp_valid=0, req_ready=1; no stale response appears afterwards.
